// File: rtl/m_rx_frame_if.sv
// Byte-in / payload-and-status-out bundle between the UART receiver, the frame
// parser and the application.
interface m_rx_frame_if;
  logic       i_rx_en;
  logic [7:0] i_rx_data;
  logic       o_pl_valid;
  logic [7:0] o_pl_data;
  logic [7:0] o_pl_index;
  logic       o_frame_ok;
  logic       o_frame_err;
  logic [1:0] o_err_code;
  logic       o_busy;

  modport master (
    output i_rx_en, i_rx_data,
    input  o_pl_valid, o_pl_data, o_pl_index, o_frame_ok, o_frame_err,
           o_err_code, o_busy
  );

  modport slave (
    input  i_rx_en, i_rx_data,
    output o_pl_valid, o_pl_data, o_pl_index, o_frame_ok, o_frame_err,
           o_err_code, o_busy
  );
endinterface

// File: rtl/m_rx_frame.sv
// Receive frame parser: 55 AA header, length, payload and 8-bit additive checksum,
// with an inter-byte timeout. Payload is streamed before the checksum is known.
module m_rx_frame #(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  m_rx_frame_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, HDR2, LEN, PAYLOAD, CSUM} state_t;

  localparam int             TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]     MAXL    = 8'(MAX_LEN);

  state_t        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    acc_q, acc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic          pl_valid_q, pl_valid_d;
  logic [7:0]    pl_data_q, pl_data_d;
  logic [7:0]    pl_index_q, pl_index_d;
  logic          ok_q, ok_d;
  logic          err_q, err_d;
  logic [1:0]    code_q, code_d;
  logic          timeout;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      to_q       <= '0;
      pl_valid_q <= 1'b0;
      pl_data_q  <= '0;
      pl_index_q <= '0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      pl_valid_q <= pl_valid_d;
      pl_data_q  <= pl_data_d;
      pl_index_q <= pl_index_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    pl_valid_d = 1'b0;
    pl_data_d  = pl_data_q;
    pl_index_d = pl_index_q;
    ok_d       = 1'b0;
    err_d      = 1'b0;
    code_d     = code_q;

    // A byte in the same cycle always wins over the timeout.
    timeout = (state_q != IDLE) && !bus.i_rx_en && (to_q == TO_LAST);

    if (bus.i_rx_en) begin
      case (state_q)
        IDLE: if (bus.i_rx_data == 8'h55) state_d = HDR2;
        HDR2: begin
          if (bus.i_rx_data == 8'hAA)      state_d = LEN;
          else if (bus.i_rx_data != 8'h55) state_d = IDLE;
        end
        LEN: begin
          if (bus.i_rx_data == 8'd0 || bus.i_rx_data > MAXL) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = 2'd1;
          end else begin
            len_d   = bus.i_rx_data;
            acc_d   = bus.i_rx_data;
            cnt_d   = '0;
            state_d = PAYLOAD;
          end
        end
        PAYLOAD: begin
          pl_valid_d = 1'b1;
          pl_data_d  = bus.i_rx_data;
          pl_index_d = cnt_q;
          acc_d      = acc_q + bus.i_rx_data;
          cnt_d      = cnt_q + 8'd1;
          if (cnt_q == len_q - 8'd1) state_d = CSUM;
        end
        CSUM: begin
          state_d = IDLE;
          if (bus.i_rx_data == acc_q) begin
            ok_d = 1'b1;
          end else begin
            err_d  = 1'b1;
            code_d = 2'd2;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
      code_d  = 2'd3;
    end

    to_d = (state_d == IDLE || bus.i_rx_en) ? '0 : to_q + 1'b1;
  end

  assign bus.o_pl_valid  = pl_valid_q;
  assign bus.o_pl_data   = pl_data_q;
  assign bus.o_pl_index  = pl_index_q;
  assign bus.o_frame_ok  = ok_q;
  assign bus.o_frame_err = err_q;
  assign bus.o_err_code  = code_q;
  assign bus.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_m_rx_frame.sv
// Scoreboard bench for m_rx_frame: expected payload strobes and frame results are
// queued as bytes are driven and matched when the DUT emits them.
module tb_m_rx_frame;
  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  m_rx_frame_if bus();

  m_rx_frame #(.MAX_LEN(16), .TIMEOUT_CYCLES(20)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] pl_q[$];   // {data, index}
  logic [2:0]  ev_q[$];   // 3'b000 = ok, {1'b1, code} = error

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (bus.o_pl_valid) begin
        n_chk++;
        if (pl_q.size() == 0) begin
          n_fail++;
          $display("FAIL pl_unexpected: got data=%h idx=%0d, none expected", bus.o_pl_data, bus.o_pl_index);
        end else begin
          logic [15:0] e;
          e = pl_q.pop_front();
          if ({bus.o_pl_data, bus.o_pl_index} !== e) begin
            n_fail++;
            $display("FAIL pl_data: got data=%h idx=%0d, want data=%h idx=%0d",
                     bus.o_pl_data, bus.o_pl_index, e[15:8], e[7:0]);
          end
        end
      end
      if (bus.o_frame_ok && bus.o_frame_err) begin
        n_chk++;
        n_fail++;
        $display("FAIL ok_err_together: both pulses high");
      end
      if (bus.o_frame_ok || bus.o_frame_err) begin
        logic [2:0] o;
        o = bus.o_frame_ok ? 3'b000 : {1'b1, bus.o_err_code};
        n_chk++;
        if (ev_q.size() == 0) begin
          n_fail++;
          $display("FAIL ev_unexpected: got ev=%b, none expected", o);
        end else begin
          logic [2:0] e;
          e = ev_q.pop_front();
          if (o !== e) begin
            n_fail++;
            $display("FAIL frame_result: got ev=%b, want ev=%b", o, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_clk);
    bus.i_rx_en = 1'b1;
    bus.i_rx_data = b;
    @(negedge i_clk);
    bus.i_rx_en = 1'b0;
  endtask

  task automatic exp_pl(input logic [7:0] d, input logic [7:0] idx);
    pl_q.push_back({d, idx});
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge i_clk);
    n_chk++;
    if (pl_q.size() != 0 || ev_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: pending pl=%0d ev=%0d, want 0/0", name, pl_q.size(), ev_q.size());
    end
  endtask

  task automatic test_reset();
    bus.i_rx_en = 1'b0;
    bus.i_rx_data = 8'h00;
    repeat (3) @(negedge i_clk);
    n_chk++;
    if ({bus.o_pl_valid, bus.o_pl_data, bus.o_pl_index, bus.o_frame_ok, bus.o_frame_err,
         bus.o_err_code, bus.o_busy} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got nonzero outputs, want all 0");
    end
    i_rst_n = 1'b1;
  endtask

  task automatic test_good_frame();
    send_byte(8'h55);
    n_chk++;
    if (bus.o_busy !== 1'b1) begin n_fail++; $display("FAIL good_busy_rise: got %b want 1", bus.o_busy); end
    send_byte(8'hAA); send_byte(8'h03);
    exp_pl(8'h11, 0); exp_pl(8'h22, 1); exp_pl(8'h33, 2);
    ev_q.push_back(3'b000);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    n_chk++;
    if ({bus.o_frame_ok, bus.o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL good_ok_timing: got ok,busy=%b%b want 10", bus.o_frame_ok, bus.o_busy);
    end
    drain("good");
  endtask

  task automatic test_bad_csum();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    exp_pl(8'h11, 0); exp_pl(8'h22, 1); exp_pl(8'h33, 2);
    ev_q.push_back({1'b1, 2'd2});
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h68);
    n_chk++;
    if ({bus.o_frame_err, bus.o_err_code, bus.o_frame_ok} !== 4'b1100) begin
      n_fail++;
      $display("FAIL csum_err: got err,code,ok=%b,%0d,%b want 1,2,0", bus.o_frame_err, bus.o_err_code, bus.o_frame_ok);
    end
    drain("csum");
  endtask

  task automatic test_bad_len();
    logic [7:0] acc;
    ev_q.push_back({1'b1, 2'd1});
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
    n_chk++;
    if ({bus.o_frame_err, bus.o_err_code, bus.o_busy} !== 4'b1010) begin
      n_fail++;
      $display("FAIL len_zero: got err,code,busy=%b,%0d,%b want 1,1,0", bus.o_frame_err, bus.o_err_code, bus.o_busy);
    end
    ev_q.push_back({1'b1, 2'd1});
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11);
    n_chk++;
    if ({bus.o_frame_err, bus.o_err_code} !== 3'b101) begin
      n_fail++;
      $display("FAIL len_over: got err,code=%b,%0d want 1,1", bus.o_frame_err, bus.o_err_code);
    end
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h10);
    acc = 8'h10;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      b = 8'(i * 7 + 3);
      acc = acc + b;
      exp_pl(b, 8'(i));
      if (i == 15) ev_q.push_back(3'b000);
      send_byte(b);
    end
    n_chk++;
    if (bus.o_pl_index !== 8'd15) begin
      n_fail++;
      $display("FAIL len_max_last_idx: got %0d want 15", bus.o_pl_index);
    end
    send_byte(acc);
    n_chk++;
    if (bus.o_frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL len_max_ok: got %b want 1", bus.o_frame_ok);
    end
    drain("len");
  endtask

  task automatic test_resync();
    send_byte(8'h00); send_byte(8'h55); send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    exp_pl(8'h7F, 0);
    ev_q.push_back(3'b000);
    send_byte(8'h7F);
    send_byte(8'h80);
    n_chk++;
    if (bus.o_frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_ok: got %b want 1", bus.o_frame_ok);
    end
    send_byte(8'h55);
    send_byte(8'h12);
    n_chk++;
    if ({bus.o_busy, bus.o_frame_err, bus.o_frame_ok} !== 3'b000) begin
      n_fail++;
      $display("FAIL junk_hdr: got busy,err,ok=%b%b%b want 000", bus.o_busy, bus.o_frame_err, bus.o_frame_ok);
    end
    drain("resync");
  endtask

  task automatic test_timeout();
    int early;
    early = 0;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    exp_pl(8'h10, 0);
    ev_q.push_back({1'b1, 2'd3});
    send_byte(8'h10);
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (k < 20 && bus.o_frame_err) early = k;
    end
    n_chk++;
    if (early != 0) begin
      n_fail++;
      $display("FAIL timeout_early: err fired %0d cycles after byte, want 20", early);
    end
    n_chk++;
    if ({bus.o_frame_err, bus.o_err_code, bus.o_busy} !== 4'b1110) begin
      n_fail++;
      $display("FAIL timeout_fire: got err,code,busy=%b,%0d,%b want 1,3,0", bus.o_frame_err, bus.o_err_code, bus.o_busy);
    end
    drain("timeout");

    // Second payload byte lands in the last allowed cycle.
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
    exp_pl(8'h10, 0); exp_pl(8'h20, 1);
    send_byte(8'h10);
    repeat (18) @(negedge i_clk);
    send_byte(8'h20);
    n_chk++;
    if ({bus.o_pl_valid, bus.o_frame_err, bus.o_busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL timeout_late_byte: got valid,err,busy=%b%b%b want 101", bus.o_pl_valid, bus.o_frame_err, bus.o_busy);
    end
    ev_q.push_back(3'b000);
    send_byte(8'h32);
    drain("timeout_late");
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [7];
    seq = '{8'h55, 8'hAA, 8'h02, 8'hC0, 8'h41, 8'h03, 8'h55};
    exp_pl(8'hC0, 0); exp_pl(8'h41, 1);
    ev_q.push_back(3'b000);
    @(negedge i_clk);
    for (int i = 0; i < 6; i++) begin
      bus.i_rx_en = 1'b1;
      bus.i_rx_data = seq[i];
      @(negedge i_clk);
    end
    bus.i_rx_en = 1'b0;
    n_chk++;
    if ({bus.o_frame_ok, bus.o_busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_ok: got ok,busy=%b%b want 10", bus.o_frame_ok, bus.o_busy);
    end
    drain("b2b");
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03);
    exp_pl(8'h11, 0);
    send_byte(8'h11);
    #2;
    i_rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.o_pl_valid, bus.o_pl_data, bus.o_pl_index, bus.o_frame_ok, bus.o_frame_err,
         bus.o_err_code, bus.o_busy} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_async: got data=%h busy=%b valid=%b, want all 0", bus.o_pl_data, bus.o_busy, bus.o_pl_valid);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h01);
    exp_pl(8'h05, 0);
    ev_q.push_back(3'b000);
    send_byte(8'h05);
    send_byte(8'h06);
    n_chk++;
    if (bus.o_frame_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_then_ok: got %b want 1", bus.o_frame_ok);
    end
    drain("reset_mid");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_resync();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/m_rx_frame.md
# m_rx_frame

Receive-side frame parser sitting directly downstream of the UART serial-to-parallel receiver. It consumes the receiver's one-cycle byte strobe and data, hunts for a two-byte header, and checks a length field and an 8-bit additive checksum. It streams payload bytes to the application and finishes every frame with exactly one ok or error pulse. An inter-byte timeout aborts stalled frames.

## Interface
- MAX_LEN, 16: largest legal payload length in bytes; legal range 1..255.
- TIMEOUT_CYCLES, 100000: idle clock cycles allowed between bytes inside a frame; must be ≥ 2.

- i_clk  input  1  system clock.
- i_rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- i_rx_en  input  1  byte-valid strobe from the UART receiver; one cycle wide.
- i_rx_data  input  8  received byte; valid only while i_rx_en is high.
- o_pl_valid  output  1  one-cycle strobe: payload byte available.
- o_pl_data  output  8  payload byte; holds its value between strobes.
- o_pl_index  output  8  0-based position of o_pl_data within the payload.
- o_frame_ok  output  1  one-cycle pulse: frame complete and checksum matched.
- o_frame_err  output  1  one-cycle pulse: frame aborted.
- o_err_code  output  2  cause of the last error: 1 = bad length, 2 = checksum mismatch, 3 = timeout. Updated only with o_frame_err and held otherwise.
- o_busy  output  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, HDR2, LEN, PAYLOAD, CSUM. A state changes only on an i_rx_en cycle, except for a timeout.
- IDLE: a byte of 0x55 moves to HDR2. Any other byte is ignored.
- HDR2: 0xAA moves to LEN. 0x55 stays in HDR2 (resync). Any other byte returns to IDLE with no error pulse.
- LEN: a byte of 0 or a byte greater than MAX_LEN pulses o_frame_err with code 1 and returns to IDLE. Otherwise:
  - store the length;
  - set checksum accumulator = length byte;
  - set payload counter = 0;
  - go to PAYLOAD.
- PAYLOAD, for each byte:
  - o_pl_data = byte and o_pl_index = counter;
  - pulse o_pl_valid;
  - accumulator += byte, mod 256;
  - counter++.
  - After the length-th payload byte, go to CSUM.
- CSUM: if the byte equals the accumulator, pulse o_frame_ok. Otherwise pulse o_frame_err with code 2. Either way, go to IDLE.
- Payload bytes are forwarded before the checksum is known. A consumer discards the buffered payload on o_frame_err.
- Timeout counter:
  - held at 0 in IDLE;
  - cleared on every i_rx_en;
  - otherwise increments once per cycle;
  - width is $clog2(TIMEOUT_CYCLES+1).
- Timeout firing: when the counter equals TIMEOUT_CYCLES−1 and i_rx_en is low, the next edge returns to IDLE and pulses o_frame_err with code 3.
- A timeout applies in HDR2, LEN, PAYLOAD and CSUM.
- Simultaneous events:
  - i_rx_en in the same cycle as a timeout: the byte is processed and the timeout is suppressed.
  - o_frame_ok and o_frame_err never assert together.
- Only one frame is in flight at a time. A header arriving mid-frame is treated as a payload or checksum byte.

## Timing
- All outputs are registered. Every response appears on the first rising edge after the i_rx_en cycle that causes it, so latency is 1 cycle.
- o_busy is asserted from the edge after an accepted 0x55 in IDLE until the edge that returns the block to IDLE.
- i_rx_en is never issued on consecutive cycles by the upstream receiver. The block nevertheless accepts back-to-back strobes, one byte per cycle.
- Reset (asynchronous, any state, including mid-frame):
  - state = IDLE; accumulator, counters and timeout counter = 0;
  - all outputs = 0;
  - no error pulse is generated for the aborted frame.
- After reset deassertion, the first i_rx_en is processed normally.

## Test plan
- Good frame: 55 AA 03 11 22 33 69.
  - o_pl_valid three times with (11,0), (22,1), (33,2).
  - o_frame_ok one cycle after 0x69.
  - o_busy drops on the same edge.
- Bad checksum: 55 AA 03 11 22 33 68.
  - Three payload strobes.
  - o_frame_err with o_err_code = 2.
  - No o_frame_ok.
- Bad length, with MAX_LEN = 16:
  - 55 AA 00 gives code 1.
  - 55 AA 11 gives code 1.
  - 55 AA 10 followed by 16 payload bytes and the correct checksum gives o_frame_ok, with the last index = 15.
- Resync and junk:
  - 00 55 55 AA 01 7F 80 gives one payload strobe (7F,0), then o_frame_ok.
  - 55 12 gives no pulses and returns to IDLE.
- Timeout, with TIMEOUT_CYCLES = 20:
  - 55 AA 02 10 followed by silence gives o_frame_err with code 3 exactly 20 cycles after the edge that accepted 0x10.
  - A byte arriving on cycle 19 is accepted instead, and no error fires.
- Reset mid-frame: assert i_rst_n low after 55 AA 03 11.
  - All outputs read 0 asynchronously.
  - A following clean frame 55 AA 01 05 06 gives o_frame_ok.
